alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit registered ALU.
- Adds a generic operand width, a valid/ready handshake on input and output, and iterative multi-cycle multiply and divide.
- Adds full N/V/C/Z flags and divide-by-zero detection.
- Sits between the operand/opcode issue logic and the result writeback register.
- Holds exactly one operation in flight.

Parameters:
- WIDTH, 8: operand width in bits; legal values 4..32.
- OPW, 4: opcode width; fixed at 4, exposed for lint only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  2*WIDTH  result
- carry  out  1  carry / borrow / shifted-out bit
- zero  out  1  y == 0
- negative  out  1  MSB of the WIDTH-bit result (y[WIDTH-1])
- overflow  out  1  signed overflow, ADD/SUB/INC/DEC only
- div_by_zero  out  1  DIV issued with b == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1; out_valid=0; y=0; all flags 0; operand and iteration registers cleared.
- Reset mid-operation aborts the operation; no result is produced.
- Accept: on a clk edge with in_valid && in_ready, capture a, b, op into internal registers. in_ready drops the next cycle.
- Opcodes:
  - 0 ADD; 1 SUB (a-b); 2 INC (a+1); 3 DEC (a-1); 4 MUL; 5 DIV.
  - 6 AND; 7 OR; 8 XOR; 9 NAND; 10 NOR; 11 XNOR.
  - 12 SHL; 13 SHR (logical); 14 ROR by 1; 15 ROL by 1.
- Width rules: every op except MUL/DIV gives a WIDTH-bit result, zero-extended into y.
  - MUL: y = full 2*WIDTH unsigned product.
  - DIV: y = {remainder, quotient}, each WIDTH bits, unsigned.
- carry:
  - ADD/INC: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB/DEC: borrow, i.e. 1 when a < subtrahend.
  - SHL: a[WIDTH-1]. SHR: a[0].
  - All other ops: 0.
- overflow: two's-complement overflow of the WIDTH-bit ADD/SUB/INC/DEC; 0 otherwise.
- zero: 1 iff the entire 2*WIDTH-bit y == 0. Evaluated on the final result.
- FSM states:
  - IDLE: in_ready=1. On accept, go to EXEC if op is not 4/5, else to ITER. Exception: DIV with b==0 goes to EXEC.
  - EXEC: compute the combinational result; register y and flags; go to DONE. Total latency: out_valid asserts 2 cycles after the accept edge.
  - ITER: MUL is shift-add; DIV is restoring, one bit per cycle. Iteration counter runs WIDTH cycles (0..WIDTH-1). After the last iteration, register y and flags and go to DONE. Latency is WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1; y and flags held stable. On out_ready go to IDLE, with in_ready=1 the following cycle.
- No overlap: a new operation cannot be accepted in the same cycle as a result handshake. Minimum throughput is one op per 3 cycles.
- Divide by zero: quotient = all ones, remainder = a, div_by_zero=1, carry=0. Takes the single-cycle EXEC path.
- div_by_zero is 0 for every other result. Flags update only when y updates.
- Inputs a, b, op are ignored when in_ready=0. Changes during ITER must not affect the result.
- out_valid stays high until out_ready. y and flags must not change while out_valid=1 && !out_ready.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- WIDTH=8. ADD a=0xFF, b=0x01 -> y=0x0000, carry=1, zero=1, overflow=0, out_valid 2 cycles after accept.
- SUB a=0x80, b=0x01 -> y=0x007F, carry=0, overflow=1, negative=0; then SUB a=0x01, b=0x02 -> y=0x00FF, carry=1, negative=1.
- MUL a=0xFF, b=0xFF -> y=0xFE01, out_valid exactly 9 cycles after accept; toggle a/b during ITER -> result unchanged.
- DIV a=200, b=7 -> y={0x04,0x1C}=0x041C. DIV a=0x55, b=0 -> y=0x55FF, div_by_zero=1, latency 2.
- Hold out_ready=0 for 5 cycles after a ROL of 0x81 -> y=0x0003 stable and in_ready=0 throughout; release -> in_ready=1 next cycle.
- Assert rst_n low during MUL iteration 4 -> out_valid=0, y=0, in_ready=1 immediately; next ADD 3+4 -> y=0x0007, zero=0.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: one operation in flight, single-cycle logic/arith ops,
// iterative shift-add multiply and restoring divide, registered result and N/V/C/Z flags.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [OPW-1:0]     op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] y,
   output logic               carry,
   output logic               zero,
   output logic               negative,
   output logic               overflow,
   output logic               div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
   localparam logic [OPW-1:0] OP_INC  = OPW'(2);
   localparam logic [OPW-1:0] OP_DEC  = OPW'(3);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(4);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(5);
   localparam logic [OPW-1:0] OP_AND  = OPW'(6);
   localparam logic [OPW-1:0] OP_OR   = OPW'(7);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(8);
   localparam logic [OPW-1:0] OP_NAND = OPW'(9);
   localparam logic [OPW-1:0] OP_NOR  = OPW'(10);
   localparam logic [OPW-1:0] OP_XNOR = OPW'(11);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(12);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(13);
   localparam logic [OPW-1:0] OP_ROR  = OPW'(14);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(15);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [OPW-1:0]       op_q, op_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   y_q, y_d;
   logic                 c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d, dz_q, dz_d;

   // Single-cycle datapath, driven from the captured operands only
   logic [WIDTH-1:0]     rhs, exec_lo, exec_hi;
   logic [WIDTH:0]       arith;
   logic                 exec_c, exec_v, exec_dz;

   always_comb begin
      exec_lo = '0;
      exec_hi = '0;
      exec_c  = 1'b0;
      exec_v  = 1'b0;
      exec_dz = 1'b0;
      arith   = '0;
      rhs     = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WIDTH'(1) : b_q;
      case (op_q)
         OP_ADD, OP_INC: begin
            arith   = {1'b0, a_q} + {1'b0, rhs};
            exec_lo = arith[WIDTH-1:0];
            exec_c  = arith[WIDTH];
            exec_v  = (a_q[WIDTH-1] == rhs[WIDTH-1]) && (arith[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB, OP_DEC: begin
            arith   = {1'b0, a_q} - {1'b0, rhs};
            exec_lo = arith[WIDTH-1:0];
            exec_c  = arith[WIDTH];
            exec_v  = (a_q[WIDTH-1] != rhs[WIDTH-1]) && (arith[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_DIV: begin
            // Only reached here for a zero divisor
            exec_lo = '1;
            exec_hi = a_q;
            exec_dz = 1'b1;
         end
         OP_AND:  exec_lo = a_q & b_q;
         OP_OR:   exec_lo = a_q | b_q;
         OP_XOR:  exec_lo = a_q ^ b_q;
         OP_NAND: exec_lo = ~(a_q & b_q);
         OP_NOR:  exec_lo = ~(a_q | b_q);
         OP_XNOR: exec_lo = ~(a_q ^ b_q);
         OP_SHL: begin
            exec_lo = {a_q[WIDTH-2:0], 1'b0};
            exec_c  = a_q[WIDTH-1];
         end
         OP_SHR: begin
            exec_lo = {1'b0, a_q[WIDTH-1:1]};
            exec_c  = a_q[0];
         end
         OP_ROR:  exec_lo = {a_q[0], a_q[WIDTH-1:1]};
         OP_ROL:  exec_lo = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
         default: exec_lo = '0;
      endcase
   end

   // One iteration step. MUL: acc = {partial hi, multiplier}; DIV: acc = {remainder, dividend/quotient}
   logic [WIDTH:0]       mul_sum, div_sh;
   logic [WIDTH-1:0]     div_rem;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   iter_next;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = div_sh >= {1'b0, b_q};
      div_rem   = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
      iter_next = (op_q == OP_DIV) ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                                   : {mul_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      y_d     = y_q;
      c_d     = c_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d   = a;
               b_d   = b;
               op_d  = op;
               cnt_d = '0;
               acc_d = (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
               if ((op == OP_MUL) || ((op == OP_DIV) && (b != '0))) state_d = S_ITER;
               else                                                 state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            y_d     = {exec_hi, exec_lo};
            c_d     = exec_c;
            v_d     = exec_v;
            dz_d    = exec_dz;
            z_d     = ({exec_hi, exec_lo} == '0);
            n_d     = exec_lo[WIDTH-1];
            state_d = S_DONE;
         end
         S_ITER: begin
            acc_d = iter_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               y_d     = iter_next;
               c_d     = 1'b0;
               v_d     = 1'b0;
               dz_d    = 1'b0;
               z_d     = (iter_next == '0);
               n_d     = iter_next[WIDTH-1];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         c_q     <= c_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign y           = y_q;
   assign carry       = c_q;
   assign zero        = z_q;
   assign negative    = n_q;
   assign overflow    = v_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): vector table through a scoreboard queue,
// plus hand-written sequences for operand wiggling, output back-pressure and mid-op reset.
module tb_alu_seq;
   localparam int W = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]    a, b;
   logic [3:0]      op;
   logic [2*W-1:0]  y;
   logic            carry, zero, negative, overflow, div_by_zero;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .OPW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .carry(carry), .zero(zero), .negative(negative),
      .overflow(overflow), .div_by_zero(div_by_zero)
   );

   typedef struct {
      string        name;
      logic [3:0]   op;
      logic [7:0]   a, b;
      logic [15:0]  y;
      logic         c, z, n, v, dz;
      int           lat;
   } vec_t;

   typedef struct {
      string        name;
      logic [15:0]  y;
      logic         c, z, n, v, dz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
      end
   endtask

   // Latency counts clock edges from the accept edge up to the edge at which
   // the consumer first samples out_valid high.
   task automatic run_op(input string nm, input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] ey, input logic ec, input logic ez, input logic en,
                         input logic ev, input logic edz, input int elat, input bit wiggle, input int hold);
      exp_t e;
      exp_t g;
      int   lat;
      int   k;
      op = o; a = aa; b = bb; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1; k++;
      end
      chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.name = nm; e.y = ey; e.c = ec; e.z = ez; e.n = en; e.v = ev; e.dz = edz; e.lat = elat;
      sb.push_back(e);
      lat = 1;
      while (!out_valid && lat < 100) begin
         if (wiggle) begin
            a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); in_valid = 1'b1;
         end
         @(posedge clk); #1; lat++;
      end
      in_valid = 1'b0;
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s: scoreboard empty at result", nm);
      end else begin
         g = sb.pop_front();
         chk({g.name, " latency"}, 32'(lat), 32'(g.lat));
         chk({g.name, " y"}, 32'(y), 32'(g.y));
         chk({g.name, " carry"}, 32'(carry), 32'(g.c));
         chk({g.name, " zero"}, 32'(zero), 32'(g.z));
         chk({g.name, " negative"}, 32'(negative), 32'(g.n));
         chk({g.name, " overflow"}, 32'(overflow), 32'(g.v));
         chk({g.name, " div_by_zero"}, 32'(div_by_zero), 32'(g.dz));
         $display("op %-12s a=%02h b=%02h y=%04h c=%0d z=%0d n=%0d v=%0d dz=%0d lat=%0d",
                  nm, aa, bb, y, carry, zero, negative, overflow, div_by_zero, lat);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({g.name, " hold y"}, 32'(y), 32'(g.y));
            chk({g.name, " hold out_valid"}, 32'(out_valid), 32'd1);
            chk({g.name, " hold in_ready"}, 32'(in_ready), 32'd0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " in_ready after handshake"}, 32'(in_ready), 32'd1);
      chk({nm, " out_valid after handshake"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      tbl.push_back('{"ADD ff+01",  4'd0,  8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"SUB 80-01",  4'd1,  8'h80, 8'h01, 16'h007F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2});
      tbl.push_back('{"SUB 01-02",  4'd1,  8'h01, 8'h02, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2});
      tbl.push_back('{"DIV 200/7",  4'd5,  8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9});
      tbl.push_back('{"DIV 55/0",   4'd5,  8'h55, 8'h00, 16'h55FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2});
      tbl.push_back('{"DIV ff/10",  4'd5,  8'hFF, 8'h10, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9});
      tbl.push_back('{"MUL 00*05",  4'd4,  8'h00, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9});
      tbl.push_back('{"MUL 0d*0b",  4'd4,  8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9});
      tbl.push_back('{"INC 7f",     4'd2,  8'h7F, 8'h00, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2});
      tbl.push_back('{"INC ff",     4'd2,  8'hFF, 8'h33, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"DEC 00",     4'd3,  8'h00, 8'h00, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2});
      tbl.push_back('{"ADD 7f+01",  4'd0,  8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2});
      tbl.push_back('{"AND",        4'd6,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"OR",         4'd7,  8'h0F, 8'h30, 16'h003F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"XOR",        4'd8,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2});
      tbl.push_back('{"NAND",       4'd9,  8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"NOR",        4'd10, 8'h00, 8'h00, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2});
      tbl.push_back('{"XNOR",       4'd11, 8'hA5, 8'h5A, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"SHL 81",     4'd12, 8'h81, 8'h00, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"SHR 81",     4'd13, 8'h81, 8'h00, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2});
      tbl.push_back('{"ROR 01",     4'd14, 8'h01, 8'h00, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2});

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset y", 32'(y), 32'd0);
      chk("reset flags", 32'({carry, zero, negative, overflow, div_by_zero}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // out_ready while idle must not disturb anything
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle out_ready out_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].c, tbl[i].z,
                tbl[i].n, tbl[i].v, tbl[i].dz, tbl[i].lat, 1'b0, 0);
      end

      // Operand/opcode inputs toggle throughout the iteration
      run_op("MUL ff*ff", 4'd4, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1, 0);
      run_op("DIV wiggle", 4'd5, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1, 0);

      // Result held under back-pressure
      run_op("ROL 81", 4'd15, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 5);

      // Asynchronous reset during MUL iteration 4 aborts the operation
      op = 4'd4; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid-mul out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort in_ready", 32'(in_ready), 32'd1);
      chk("abort y", 32'(y), 32'd0);
      chk("abort flags", 32'({carry, zero, negative, overflow, div_by_zero}), 32'd0);
      $display("reset during MUL: out_valid=%0d in_ready=%0d y=%04h", out_valid, in_ready, y);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("ADD 3+4", 4'd0, 8'h03, 8'h04, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0);

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
